// File: rtl/out_arbiter_4.sv
// out_arbiter_4: four-input packet arbiter feeding one output buffer.
// A requester presenting a header (BOP) flit wins a round-robin arbitration and keeps
// the output until its tail (EOP) flit transfers. Transfers are combinational on the
// current owner's req and !full.
// Optional feature: define ARB_TIMEOUT_EN to force release of a lock that has
// seen no transfer for TIMEOUT_CYC consecutive cycles (pulses timeout_err).
module out_arbiter_4 #(
   parameter int unsigned FLIT_W      = 67,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        req,
   input  logic [FLIT_W-1:0] flit_in_0,
   input  logic [FLIT_W-1:0] flit_in_1,
   input  logic [FLIT_W-1:0] flit_in_2,
   input  logic [FLIT_W-1:0] flit_in_3,
   output logic [3:0]        ack,
   input  logic              full,
   output logic              write,
   output logic [FLIT_W-1:0] data_out,
   output logic [3:0]        grant,
   output logic              busy,
   output logic              timeout_err
);

   typedef enum logic [0:0] {StIdle, StLocked} state_e;

   state_e            state_q, state_d;
   logic [3:0]        grant_q, grant_d;
   logic [1:0]        owner_q, owner_d;
   logic [1:0]        rr_ptr_q, rr_ptr_d;
   logic [FLIT_W-1:0] flits [4];
   logic [FLIT_W-1:0] owner_flit;
   logic              transfer;
   logic              release_lock;
   logic              expire;
   logic              found;
   logic [1:0]        pick;
   logic [1:0]        cand;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            timeout_err_q, timeout_err_d;
`else
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

   // Collect the requester flits into an indexable array.
   always_comb begin
      flits[0] = flit_in_0;
      flits[1] = flit_in_1;
      flits[2] = flit_in_2;
      flits[3] = flit_in_3;
   end

   // Round-robin search for the first header-bearing request at or after rr_ptr.
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr_q;
      cand  = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         cand = rr_ptr_q + 2'(i);
         if (!found && req[cand] && flits[cand][FLIT_W-1]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Next-state, transfer datapath and lock release.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      owner_d      = owner_q;
      rr_ptr_d     = rr_ptr_q;
      write        = 1'b0;
      ack          = '0;
      data_out     = '0;
      transfer     = 1'b0;
      release_lock = 1'b0;
      expire       = 1'b0;
      owner_flit   = flits[owner_q];

      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d = StLocked;
               grant_d = 4'b0001 << pick;
               owner_d = pick;
            end
         end
         StLocked: begin
            // Outputs are gated during reset so a dying lock never acks a flit.
            if (rst) begin
               data_out = owner_flit;
               transfer = req[owner_q] & ~full;
            end
            if (transfer) begin
               write          = 1'b1;
               ack[owner_q]   = 1'b1;
               release_lock   = owner_flit[FLIT_W-2];
            end
         end
         default: state_d = StIdle;
      endcase

`ifdef ARB_TIMEOUT_EN
      cnt_d         = '0;
      timeout_err_d = 1'b0;
      if (state_q == StLocked && !transfer) begin
         cnt_d = cnt_q + CntW'(1);
         if (cnt_d == CntMax) begin
            expire        = 1'b1;
            timeout_err_d = 1'b1;
            cnt_d         = '0;
         end
      end
`endif

      if (release_lock || expire) begin
         state_d  = StIdle;
         grant_d  = '0;
         rr_ptr_d = owner_q + 2'd1;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Idle-lock counter and one-cycle forced-release pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign grant = grant_q;
   assign busy  = (state_q == StLocked);

endmodule
